// File: rtl/gate_pkg.sv
// gate_pkg: shared types and helpers for the gate_bank lane array.
//   lane_state_e : per-lane power state (OFF, WAKE, ON)
//   clog2/cnt_w  : elaboration-time sizing of the wake and idle counters
package gate_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2
  } lane_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A counter that must hold 0..n-1 needs clog2(n) bits, but never fewer than 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/gate_bank_if.sv
// gate_bank_if: producer-side bundle for gate_bank.
//   global_enable : master gate (low forces every lane OFF)
//   keep_on       : per-lane idle override
//   in_valid/in   : per-lane request and data (lane k at [k*WIDTH +: WIDTH])
//   in_ready      : per-lane accept
//   out/out_valid : captured data and one-cycle capture pulse
//   active        : lane is in WAKE or ON
// master = producer / power manager side, slave = gate_bank.
interface gate_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                      global_enable;
  logic [CHANNELS-1:0]       keep_on;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] out;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       active;

  modport master (
    output global_enable, keep_on, in_valid, in,
    input  in_ready, out, out_valid, active
  );

  modport slave (
    input  global_enable, keep_on, in_valid, in,
    output in_ready, out, out_valid, active
  );
endinterface

// File: rtl/gate_channel.sv
// gate_channel: one lane of gate_bank.
// Power FSM (OFF -> WAKE -> ON -> OFF) with a wake-up delay and idle
// auto-gating, plus a WIDTH-bit capture register clock-enabled by the
// handshake. All state lives on the single _clock.
// Ports:
//   _clock, _reset         : clock, asynchronous active-low reset
//   global_enable, keep_on : master gate, idle override
//   in_valid, in_data      : request and data
//   in_ready               : accept (combinational from state and global_enable)
//   out_data, out_valid    : captured data, one-cycle capture pulse
//   active                 : registered (state != OFF)
module gate_channel
  import gate_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             global_enable,
  input  logic             keep_on,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             active
);

  localparam int WW = cnt_w(WAKE_CYCLES);
  localparam int IW = cnt_w(IDLE_CYCLES);
  localparam logic [WW-1:0] WAKE_LOAD = WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

  lane_state_e     state_q, state_d;
  logic [WW-1:0]   wake_cnt_q, wake_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic            out_valid_q, out_valid_d;
  logic            active_q, active_d;
  logic            transfer;

  // global_enable gates ready combinationally so a drop blocks capture at once.
  assign in_ready = (state_q == ON) && global_enable;
  assign transfer = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wake_cnt_d  = wake_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    data_d      = data_q;
    out_valid_d = transfer;

    if (transfer) data_d = in_data;

    if (!global_enable) begin
      state_d    = OFF;
      wake_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        OFF: begin
          if (in_valid) begin
            idle_cnt_d = '0;
            if (WAKE_CYCLES == 0) begin
              state_d = ON;
            end else begin
              state_d    = WAKE;
              wake_cnt_d = WAKE_LOAD;
            end
          end
        end
        // A wake, once started, runs to completion even if in_valid drops.
        WAKE: begin
          if (wake_cnt_q == '0) begin
            state_d    = ON;
            idle_cnt_d = '0;
          end else begin
            wake_cnt_d = wake_cnt_q - WW'(1);
          end
        end
        // A transfer on the threshold cycle takes priority over gating off.
        ON: begin
          if (transfer || keep_on) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_d    = OFF;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
        default: begin
          state_d    = OFF;
          wake_cnt_d = '0;
          idle_cnt_d = '0;
        end
      endcase
    end

    active_d = (state_d != OFF);
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= OFF;
      wake_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_cnt_q  <= wake_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      active_q    <= active_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = out_valid_q;
  assign active    = active_q;

endmodule

// File: rtl/gate_bank.sv
// gate_bank: CHANNELS independent power-gated capture lanes.
// Slices the interface buses per lane and fans out global_enable; all
// behaviour lives in gate_channel.
// Ports:
//   _clock : sole clock, rising edge
//   _reset : asynchronous active-low reset
//   bus    : gate_bank_if slave (enable, keep_on, request/data, ready,
//            captured data, capture pulse, activity)
module gate_bank
  import gate_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4
) (
  input logic        _clock,
  input logic        _reset,
  gate_bank_if.slave bus
);

  logic [CHANNELS-1:0]       ready;
  logic [CHANNELS-1:0]       vld;
  logic [CHANNELS-1:0]       act;
  logic [CHANNELS*WIDTH-1:0] dout;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    gate_channel #(
      .WIDTH       (WIDTH),
      .WAKE_CYCLES (WAKE_CYCLES),
      .IDLE_CYCLES (IDLE_CYCLES)
    ) u_lane (
      ._clock        (_clock),
      ._reset        (_reset),
      .global_enable (bus.global_enable),
      .keep_on       (bus.keep_on[k]),
      .in_valid      (bus.in_valid[k]),
      .in_data       (bus.in[k*WIDTH +: WIDTH]),
      .in_ready      (ready[k]),
      .out_data      (dout[k*WIDTH +: WIDTH]),
      .out_valid     (vld[k]),
      .active        (act[k])
    );
  end

  assign bus.in_ready  = ready;
  assign bus.out       = dout;
  assign bus.out_valid = vld;
  assign bus.active    = act;

endmodule

// File: tb/tb_gate_bank.sv
module tb_gate_bank;

  logic clk;
  logic rst_n;

  gate_bank_if #(.CHANNELS(4), .WIDTH(8))  bus ();
  gate_bank_if #(.CHANNELS(1), .WIDTH(16)) bus2 ();

  gate_bank #(.CHANNELS(4), .WIDTH(8), .WAKE_CYCLES(2), .IDLE_CYCLES(4)) dut (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus)
  );

  gate_bank #(.CHANNELS(1), .WIDTH(16), .WAKE_CYCLES(0), .IDLE_CYCLES(4)) dut2 (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  exp_q  [4][$];
  logic [15:0] exp2_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every capture pulse must match the oldest expected value.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.out_valid[k] === 1'b1) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("unexpected_capture_lane%0d", k), {24'd0, bus.out[k*8 +: 8]}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q[k].pop_front();
          check($sformatf("capture_lane%0d", k), {24'd0, bus.out[k*8 +: 8]}, {24'd0, e});
        end
      end
    end
    if (bus2.out_valid[0] === 1'b1) begin
      if (exp2_q.size() == 0) begin
        check("unexpected_capture_w16", {16'd0, bus2.out}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e2;
        e2 = exp2_q.pop_front();
        check("capture_w16", {16'd0, bus2.out}, {16'd0, e2});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected end before 200000", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.global_enable  = 1'b0;
    bus.keep_on        = '0;
    bus.in_valid       = '0;
    bus.in             = '0;
    bus2.global_enable = 1'b0;
    bus2.keep_on       = '0;
    bus2.in_valid      = '0;
    bus2.in            = '0;

    // 1. Reset then wake
    repeat (3) step();
    check("reset_out",       bus.out,       32'h0);
    check("reset_active",    bus.active,    32'h0);
    check("reset_in_ready",  bus.in_ready,  32'h0);
    check("reset_out_valid", bus.out_valid, 32'h0);
    rst_n = 1'b1;
    bus.global_enable = 1'b1;
    bus.in_valid[0]   = 1'b1;
    bus.in[7:0]       = 8'hA5;
    step();
    check("wake_active0",   bus.active[0],   32'h1);
    check("wake_ready0_c1", bus.in_ready[0], 32'h0);
    step();
    check("wake_ready0_c2", bus.in_ready[0], 32'h0);
    step();
    check("wake_ready0_c3", bus.in_ready[0], 32'h1);
    exp_q[0].push_back(8'hA5);
    step();
    bus.in_valid[0] = 1'b0;
    check("capture_out0", bus.out[7:0], 32'hA5);

    // 2. Idle auto-gate
    repeat (3) step();
    check("idle_still_on0", bus.active[0], 32'h1);
    step();
    check("idle_off0",      bus.active[0], 32'h0);
    check("idle_out_held0", bus.out[7:0],  32'hA5);

    bus.keep_on[0]  = 1'b1;
    bus.in_valid[0] = 1'b1;
    bus.in[7:0]     = 8'h5A;
    repeat (3) step();
    check("keep_wake_ready0", bus.in_ready[0], 32'h1);
    exp_q[0].push_back(8'h5A);
    step();
    bus.in_valid[0] = 1'b0;
    repeat (20) step();
    check("keep_on_active0", bus.active[0],   32'h1);
    check("keep_on_ready0",  bus.in_ready[0], 32'h1);
    bus.keep_on[0] = 1'b0;
    repeat (3) step();
    check("keep_release_on0",  bus.active[0], 32'h1);
    step();
    check("keep_release_off0", bus.active[0], 32'h0);

    // 3. Threshold collision on lane 1
    bus.in_valid[1] = 1'b1;
    bus.in[15:8]    = 8'h77;
    repeat (3) step();
    check("coll_wake_ready1", bus.in_ready[1], 32'h1);
    exp_q[1].push_back(8'h77);
    step();
    bus.in_valid[1] = 1'b0;
    repeat (3) step();
    bus.in_valid[1] = 1'b1;
    bus.in[15:8]    = 8'h3C;
    check("coll_ready1", bus.in_ready[1], 32'h1);
    exp_q[1].push_back(8'h3C);
    step();
    bus.in_valid[1] = 1'b0;
    check("coll_stays_on1", bus.active[1],   32'h1);
    check("coll_ready_on1", bus.in_ready[1], 32'h1);
    check("coll_out1",      bus.out[15:8],   32'h3C);
    repeat (6) step();
    check("coll_eventual_off", bus.active, 32'h0);

    // 4. global_enable drop while streaming
    bus.in_valid = 4'hF;
    bus.in       = 32'h13121110;
    repeat (3) step();
    check("stream_ready_all", bus.in_ready, 32'hF);
    for (int k = 0; k < 4; k++) exp_q[k].push_back(8'h10 + 8'(k));
    step();
    check("stream_out", bus.out, 32'h13121110);
    bus.in = 32'h23222120;
    bus.global_enable = 1'b0;
    #1;
    check("ge_drop_ready", bus.in_ready, 32'h0);
    step();
    check("ge_drop_active",   bus.active, 32'h0);
    check("ge_drop_out_held", bus.out,    32'h13121110);
    bus.global_enable = 1'b1;
    #1;
    check("ge_rise_ready", bus.in_ready, 32'h0);
    step();
    check("ge_rewake_active", bus.active,   32'hF);
    check("ge_rewake_ready",  bus.in_ready, 32'h0);
    step();
    step();
    check("ge_rewake_ready_on", bus.in_ready, 32'hF);
    bus.in_valid = 4'h0;
    repeat (6) step();

    // 5. Async reset mid-WAKE on lane 2
    check("pre_reset_off", bus.active, 32'h0);
    bus.in_valid[2] = 1'b1;
    step();
    check("mid_wake_active2", bus.active[2], 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_active2", bus.active[2], 32'h0);
    check("async_rst_out",     bus.out,       32'h0);
    bus.in_valid[2] = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // 6. CHANNELS=1, WIDTH=16, WAKE_CYCLES=0
    bus2.global_enable = 1'b1;
    bus2.in_valid      = 1'b1;
    bus2.in            = 16'hBEEF;
    #1;
    check("w16_ready_off", bus2.in_ready, 32'h0);
    step();
    check("w16_ready_next", bus2.in_ready, 32'h1);
    check("w16_active",     bus2.active,   32'h1);
    exp2_q.push_back(16'hBEEF);
    step();
    check("w16_out_beef", bus2.out, 32'hBEEF);
    bus2.in = 16'h1234;
    exp2_q.push_back(16'h1234);
    step();
    bus2.in = 16'hCAFE;
    exp2_q.push_back(16'hCAFE);
    step();
    bus2.in_valid = 1'b0;
    check("w16_out_cafe", bus2.out, 32'hCAFE);
    repeat (3) step();

    for (int k = 0; k < 4; k++)
      check($sformatf("drain_lane%0d", k), exp_q[k].size(), 32'h0);
    check("drain_w16", exp2_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_bank.md
Name: gate_bank

Overview:
- Parametrised, multi-channel successor to the single-channel clock-gate/gated-register pair.
- Each of CHANNELS lanes owns a WIDTH-bit capture register. Each lane is enabled by a per-lane power state machine with a wake-up delay and idle auto-gating.
- Gating uses synchronous clock-enables on the single `_clock`. No derived or gated clocks are created.
- Sits between a producer and low-activity consumers. Lets idle lanes drop to OFF and reports lane activity to power management.

Parameters:
- CHANNELS, 4, number of independent lanes (>=1)
- WIDTH, 8, data bits per lane (>=1)
- WAKE_CYCLES, 2, cycles spent in WAKE before a lane accepts data (0 = no WAKE state)
- IDLE_CYCLES, 4, consecutive idle ON cycles before auto-gating to OFF (>=1)

Ports:
- _clock  input  1  sole clock, rising edge
- _reset  input  1  asynchronous, active-low reset
- global_enable  input  1  master gate; low forces every lane OFF
- keep_on  input  CHANNELS  per-lane override; while high, that lane's idle counter is held at 0
- in_valid  input  CHANNELS  per-lane data request
- in  input  CHANNELS*WIDTH  lane k data at bits [k*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  lane accepts data this cycle
- out  output  CHANNELS*WIDTH  captured data per lane
- out_valid  output  CHANNELS  one-cycle pulse per capture
- active  output  CHANNELS  lane is in WAKE or ON

Behaviour:
- Reset (_reset low, asynchronous):
  - all lanes go to OFF
  - out = 0, out_valid = 0, in_ready = 0, active = 0
  - wake and idle counters = 0
  - release is synchronous to the next rising edge
- Per-lane states: OFF, WAKE, ON. Lanes are fully independent except for global_enable.
- OFF:
  - in_ready = 0; out holds its last value
  - in_valid=1 && global_enable=1 → WAKE with wake counter loaded to WAKE_CYCLES-1
  - if WAKE_CYCLES=0, that condition goes directly → ON
- WAKE:
  - in_ready = 0
  - counter decrements each cycle; at 0 → ON
  - in_valid dropping during WAKE does not abort the wake
- ON:
  - in_ready = 1 while global_enable=1
  - transfer = in_valid && in_ready. On transfer: out lane <= in lane, out_valid pulses high the following cycle, idle counter <= 0.
  - capture latency is 1 cycle from the transfer edge to out/out_valid
  - no transfer and keep_on=0 → idle counter increments; when it reaches IDLE_CYCLES-1 and still no transfer → OFF next cycle
  - a transfer in the same cycle as the idle threshold wins: data is captured, counter resets, lane stays ON
- global_enable low:
  - combinationally forces in_ready=0
  - every lane → OFF on the next edge, with counters cleared
  - out holds its value; no capture occurs
  - global_enable rising with in_valid high restarts the WAKE sequence
- active = (state != OFF), registered.
- The first request after OFF costs WAKE_CYCLES+1 cycles before in_ready rises.
- In steady ON, throughput is one capture per cycle per lane.

Decomposition:
- Package gate_pkg:
  - lane state enum (OFF=2'd0, WAKE=2'd1, ON=2'd2)
  - counter width function clog2 helper
- Sub-module gate_channel (one lane: FSM, counters, WIDTH register), instantiated CHANNELS times in a generate loop.
- gate_bank itself only slices buses and fans out global_enable.

Test Plan:
1. Reset then wake: hold _reset low 3 cycles, then release.
   - Expect out=0 and active=0.
   - Then in_valid[0]=1 → active[0]=1 next cycle; in_ready[0] rises 3 cycles after the request (WAKE_CYCLES=2).
   - in[7:0]=8'hA5 captured → out[7:0]=8'hA5 with a one-cycle out_valid[0].
2. Idle auto-gate: after capture, hold in_valid[0]=0 → lane 0 returns to OFF 4 cycles later (active[0]=0), and out[7:0] stays 8'hA5.
   - Repeat with keep_on[0]=1 → lane stays ON for 20 cycles.
3. Threshold collision: lane 1 idles 3 cycles, then in_valid[1]=1 with in=8'h3C on the 4th cycle.
   - Expect capture of 8'h3C and lane stays ON.
4. global_enable drop: lanes 0–3 ON streaming 8'h10..8'h13; drop global_enable for one cycle.
   - in_ready=4'b0000 immediately, all lanes OFF next edge, out unchanged.
   - Re-enable with in_valid high → WAKE again.
5. Async reset mid-WAKE: assert _reset between clock edges while lane 2 is in WAKE.
   - Expect active[2]=0 and out=0 immediately, with no clock edge needed.
6. Param sweep: CHANNELS=1, WIDTH=16, WAKE_CYCLES=0.
   - in_ready rises the cycle after the first request.
   - 16'hBEEF captured, with back-to-back captures each cycle.
